// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: memory geometry, program-loader
// states and instruction opcodes (upper nibble of a program byte).
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef enum logic [2:0] {
    LDR_LEN  = 3'd0,
    LDR_DATA = 3'd1,
    LDR_CHK  = 3'd2,
    LDR_RUN  = 3'd3,
    LDR_ERR  = 3'd4
  } ldr_state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_DBL = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_CMA = 4'h6;

  function automatic logic [7:0] make_insn(input logic [3:0] op,
                                           input logic [3:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/mem_16x8.sv
// Register-array memory: combinational read, synchronous write, and a
// synchronous clear-all that takes priority over the write.
module mem_16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Reads return the pre-edge contents, so a same-cycle store is seen next cycle.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prog_loader_mem.sv
// Program loader plus unified CPU memory: accepts a framed byte stream
// (length, data, XOR checksum), writes it to memory and then serves the CPU.
module prog_loader_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_wr_data
);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              run_q, run_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              len_ok;
  logic              load_clr;
  logic              mem_clr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Stream handshake: a byte moves on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on the current state.
  assign in_ready = (state_q == LDR_LEN) || (state_q == LDR_DATA) ||
                    (state_q == LDR_CHK);
  assign xfer     = in_valid && in_ready;
  assign len_ok   = (in_data != '0) && (in_data <= DATA_W'(DEPTH));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    words_d  = words_q;
    ptr_d    = ptr_q;
    csum_d   = csum_q;
    load_clr = 1'b0;
    case (state_q)
      LDR_LEN: begin
        if (xfer) begin
          if (len_ok) begin
            state_d  = LDR_DATA;
            len_d    = in_data[ADDR_W:0];
            words_d  = '0;
            ptr_d    = '0;
            csum_d   = '0;
            load_clr = 1'b1;
          end else begin
            state_d = LDR_ERR;
          end
        end
      end
      LDR_DATA: begin
        if (xfer) begin
          csum_d  = csum_q ^ in_data;
          ptr_d   = ptr_q + 1'b1;
          words_d = words_q + 1'b1;
          if ((words_q + 1'b1) == len_q) begin
            state_d = LDR_CHK;
          end
        end
      end
      LDR_CHK: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? LDR_RUN : LDR_ERR;
        end
      end
      LDR_RUN, LDR_ERR: begin
        if (reload) begin
          state_d = LDR_LEN;
        end
      end
      default: state_d = LDR_LEN;
    endcase
    run_d = (state_d == LDR_RUN);
    err_d = (state_d == LDR_ERR);
  end

  // Loader owns the write port while streaming; the CPU owns it only in RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = mem_addr;
    mem_wd = mem_wr_data;
    if (state_q == LDR_DATA) begin
      mem_we = xfer;
      mem_wa = ptr_q;
      mem_wd = in_data;
    end else if (state_q == LDR_RUN) begin
      mem_we = mem_wr_en;
    end
  end

  assign mem_clr = rst || load_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LDR_LEN;
      len_q   <= '0;
      words_q <= '0;
      ptr_q   <= '0;
      csum_q  <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      ptr_q   <= ptr_d;
      csum_q  <= csum_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign cpu_run      = run_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

  mem_16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .clr     (mem_clr),
    .wr_en   (mem_we),
    .wr_addr (mem_wa),
    .wr_data (mem_wd),
    .rd_addr (mem_addr),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_prog_loader_mem.sv
// Bench for prog_loader_mem: random framed loads and CPU stores scored against
// a frame-level memory model through expected queues and a negedge monitor.
module tb_prog_loader_mem;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 16;
  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          cpu_run;
  logic          load_err;
  logic [AW:0]   words_loaded;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_en = 1'b0;
  logic [DW-1:0] mem_wr_data = '0;

  always #5 clk = ~clk;

  prog_loader_mem dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reload       (reload),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected queues: memory reads, status probes, and status-rise events
  // tagged with the cycle on which they must appear.
  logic [7:0]  rd_q[$];
  logic [7:0]  st_q[$];
  logic [39:0] evt_q[$];
  logic        probe_rd = 1'b0;
  logic        probe_st = 1'b0;

  logic [7:0] m_mem[DP];
  int         m_words;
  int         m_state;
  logic [7:0] frame_q[$];
  int         gap_mode = 0;

  function automatic logic [7:0] model_status();
    return {m_state == M_LOAD, m_state == M_RUN, m_state == M_ERR, 5'(m_words)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  logic prev_run = 1'b0;
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    logic [7:0]  act_st;
    logic [39:0] e;
    act_st = {in_ready, cpu_run, load_err, words_loaded};
    if (probe_rd) begin
      if (rd_q.size() == 0) fail_now("rd_q_empty");
      else check("mem_rd", 32'(mem_rd_data), 32'(rd_q.pop_front()));
    end
    if (probe_st) begin
      if (st_q.size() == 0) fail_now("st_q_empty");
      else check("status", 32'(act_st), 32'(st_q.pop_front()));
    end
    if ((cpu_run === 1'b1 && prev_run !== 1'b1) || (load_err === 1'b1 && prev_err !== 1'b1)) begin
      if (evt_q.size() == 0) fail_now("unexpected_status_rise");
      else begin
        e = evt_q.pop_front();
        check("evt_status", 32'(act_st), 32'(e[7:0]));
        check("evt_latency", 32'(cyc), e[39:8]);
      end
    end
    prev_run = cpu_run;
    prev_err = load_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DP; i++) m_mem[i] = 8'h00;
    m_words = 0;
    m_state = M_LOAD;
  endtask

  task automatic probe_mem(input int a);
    mem_addr = AW'(a);
    rd_q.push_back(m_mem[a]);
    probe_rd = 1'b1;
    tick();
    probe_rd = 1'b0;
  endtask

  task automatic probe_mem_all();
    for (int a = 0; a < DP; a++) probe_mem(a);
  endtask

  task automatic probe_status();
    st_q.push_back(model_status());
    probe_st = 1'b1;
    tick();
    probe_st = 1'b0;
  endtask

  // Frame-level model: what the memory and status must be after a whole frame.
  task automatic model_frame();
    int L;
    logic [7:0] x;
    L = int'(frame_q[0]);
    if (L == 0 || L > DP) begin
      m_state = M_ERR;
    end else begin
      x = 8'h00;
      for (int i = 0; i < DP; i++) m_mem[i] = 8'h00;
      for (int k = 0; k < L; k++) begin
        m_mem[k] = frame_q[1 + k];
        x = x ^ frame_q[1 + k];
      end
      m_words = L;
      m_state = (frame_q[L + 1] == x) ? M_RUN : M_ERR;
    end
  endtask

  task automatic send_bytes(input int count);
    int budget;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b0;
      if (gap_mode == 1) begin
        if (i > 0) tick();
      end else begin
        repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_data  = frame_q[i];
      budget   = 0;
      while (!in_ready && budget < 20) begin
        tick();
        budget++;
      end
      if (!in_ready) begin
        fail_now("in_ready_timeout");
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    int budget;
    send_bytes(frame_q.size());
    model_frame();
    evt_q.push_back({32'(cyc), model_status()});
    budget = 0;
    while (evt_q.size() != 0 && budget < 10) begin
      tick();
      budget++;
    end
    if (evt_q.size() != 0) begin
      fail_now("status_event_timeout");
      evt_q.delete();
    end
  endtask

  task automatic build_frame(input int L, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(L));
    x = 8'h00;
    for (int k = 0; k < L; k++) begin
      b = make_insn(4'($urandom_range(0, 6)), 4'($urandom_range(0, 15)));
      frame_q.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
    frame_q.push_back(x);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    if (m_state != M_LOAD) m_state = M_LOAD;
    probe_status();
  endtask

  // Store with a same-cycle read of the target (old data), then a re-read.
  task automatic cpu_store(input int a, input logic [7:0] d, input bit with_reload);
    mem_wr_en   = 1'b1;
    mem_addr    = AW'(a);
    mem_wr_data = d;
    reload      = with_reload;
    rd_q.push_back(m_mem[a]);
    probe_rd = 1'b1;
    tick();
    probe_rd  = 1'b0;
    mem_wr_en = 1'b0;
    reload    = 1'b0;
    if (m_state == M_RUN) begin
      m_mem[a] = d;
      if (with_reload) m_state = M_LOAD;
    end
    probe_mem(a);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    probe_status();
    probe_mem_all();

    frame_q = '{8'd3, 8'h41, 8'h85, 8'h60, 8'h64};
    send_frame();
    probe_mem_all();
    probe_status();

    do_reload();
    frame_q = '{8'd2, 8'h11, 8'h22, 8'h00};
    send_frame();
    probe_status();
    probe_mem_all();
    do_reload();
    build_frame($urandom_range(1, 16), 1'b0);
    send_frame();
    probe_status();

    do_reload();
    frame_q = '{8'd0};
    send_frame();
    probe_status();
    probe_mem_all();
    do_reload();
    frame_q = '{8'd17};
    send_frame();
    probe_mem_all();
    do_reload();

    frame_q.delete();
    frame_q.push_back(8'd16);
    for (int k = 0; k < 16; k++) frame_q.push_back(8'(8'hFF - k));
    frame_q.push_back(8'h00);
    gap_mode = 1;
    send_frame();
    gap_mode = 0;
    probe_mem_all();
    probe_status();

    cpu_store(5, 8'hA5, 1'b0);
    cpu_store(9, 8'h3C, 1'b1);
    probe_status();
    cpu_store(3, 8'h77, 1'b0);
    probe_mem_all();

    frame_q = '{8'd4, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_bytes(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    probe_status();
    probe_mem_all();
    send_frame();
    probe_mem_all();
    probe_status();

    for (int it = 0; it < 6; it++) begin
      do_reload();
      build_frame($urandom_range(1, 16), ($urandom_range(0, 3) == 0));
      send_frame();
      if (m_state == M_RUN) begin
        repeat (2) cpu_store($urandom_range(0, 15), 8'($urandom), 1'b0);
      end
      probe_status();
      probe_mem_all();
    end

    tick();
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("st_q_drained", 32'(st_q.size()), 32'd0);
    check("evt_q_drained", 32'(evt_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
